vga_rect_apb_master: RTL and testbench



---
 rtl/vga_apb_pkg.sv | 34 +++
 rtl/apb_master_port.sv | 105 ++++++++++
 rtl/vga_rect_apb_master.sv | 159 +++++++++++++++
 tb/tb_vga_rect_apb_master.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_apb_pkg.sv
// Shared types for the VGA rectangle APB initiator: register offsets, FSM and
// write-selector encodings, and the rectangle command record.
package vga_apb_pkg;

  localparam logic [3:0] ADDR_X     = 4'h0;
  localparam logic [3:0] ADDR_Y     = 4'h4;
  localparam logic [3:0] ADDR_COLOR = 4'h8;
  localparam logic [3:0] ADDR_WE    = 4'hC;

  localparam int RECT_COORD_W = 11;
  localparam int RECT_COLOR_W = 2;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} apb_mst_state_e;

  typedef enum logic [1:0] {WR_COLOR, WR_X, WR_Y, WR_WE} wr_sel_e;

  typedef struct packed {
    logic [RECT_COORD_W-1:0] x0;
    logic [RECT_COORD_W-1:0] y0;
    logic [RECT_COORD_W-1:0] x1;
    logic [RECT_COORD_W-1:0] y1;
    logic [RECT_COLOR_W-1:0] color;
  } rect_cmd_t;

  function automatic logic [3:0] reg_offset(input wr_sel_e sel);
    case (sel)
      WR_COLOR: reg_offset = ADDR_COLOR;
      WR_X:     reg_offset = ADDR_X;
      WR_Y:     reg_offset = ADDR_Y;
      default:  reg_offset = ADDR_WE;
    endcase
  endfunction

endpackage

// File: rtl/apb_master_port.sv
// APB write initiator: runs SETUP/ACCESS for each requested write and ends a
// command with a one-cycle DONE carrying the error flag. Current state on state_o.
module apb_master_port
  import vga_apb_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      start_i,
  input  logic                      last_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [APB_DATA_WIDTH-1:0] data_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      idle_o,
  output logic                      ack_o,
  output logic                      done_o,
  output logic                      err_o,
  output apb_mst_state_e            state_o
);

  apb_mst_state_e state_q, state_d;
  logic           err_q, err_d;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // pready/pslverr only matter in ACCESS; a clean ack with last_i ends the command.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SETUP;
          err_d   = 1'b0;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready_i) begin
          if (pslverr_i) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (last_i) begin
            state_d = DONE;
          end else begin
            state_d = SETUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    psel_o    = 1'b0;
    penable_o = 1'b0;
    pwrite_o  = 1'b0;
    paddr_o   = '0;
    pwdata_o  = '0;
    idle_o    = 1'b0;
    ack_o     = 1'b0;
    done_o    = 1'b0;
    err_o     = 1'b0;
    case (state_q)
      IDLE: idle_o = 1'b1;
      SETUP: begin
        psel_o   = 1'b1;
        pwrite_o = 1'b1;
        paddr_o  = addr_i;
        pwdata_o = data_i;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        pwrite_o  = 1'b1;
        paddr_o   = addr_i;
        pwdata_o  = data_i;
        ack_o     = pready_i & ~pslverr_i;
      end
      default: begin
        done_o = 1'b1;
        err_o  = err_q;
      end
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/vga_rect_apb_master.sv
// Fills a framebuffer rectangle by issuing COLOR then per-pixel X/Y/WE APB writes.
// Option VGA_RECT_ELIDE_EN: write Y only once per row (Y first, then X/WE per pixel).
module vga_rect_apb_master
  import vga_apb_pkg::*;
#(
  parameter int                      APB_ADDR_WIDTH = 12,
  parameter int                      APB_DATA_WIDTH = 32,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR    = 12'h000,
  parameter int                      COORD_W        = 11,
  parameter int                      COLOR_W        = 2
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [COORD_W-1:0]        cmd_x0_i,
  input  logic [COORD_W-1:0]        cmd_y0_i,
  input  logic [COORD_W-1:0]        cmd_x1_i,
  input  logic [COORD_W-1:0]        cmd_y1_i,
  input  logic [COLOR_W-1:0]        cmd_color_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
  output logic                      apb_pwrite_o,
  output logic                      apb_psel_o,
  output logic                      apb_penable_o,
  input  logic [APB_DATA_WIDTH-1:0] apb_prdata_i,
  input  logic                      apb_pready_i,
  input  logic                      apb_pslverr_i
);

`ifdef VGA_RECT_ELIDE_EN
  localparam wr_sel_e ROW_START = WR_Y;
`else
  localparam wr_sel_e ROW_START = WR_X;
`endif

  // Command handshake: cmd_valid_i is accepted only while cmd_ready_o is high
  // (port idle); it is not queued while busy.
  logic accept, idle, ack, last;
  logic [APB_ADDR_WIDTH-1:0] wr_addr;
  logic [APB_DATA_WIDTH-1:0] wr_data;
  apb_mst_state_e state_dbg;

  logic [COORD_W-1:0] xmin_q, xmax_q, ymin_q, ymax_q, x_q, y_q;
  logic [COORD_W-1:0] xmin_d, xmax_d, ymin_d, ymax_d, x_d, y_d;
  logic [COLOR_W-1:0] color_q, color_d;
  wr_sel_e            sel_q, sel_d;

  logic unused_prdata;
  assign unused_prdata = ^apb_prdata_i;

  assign cmd_ready_o = idle;
  assign busy_o      = ~idle;
  assign accept      = cmd_valid_i & idle;
  assign last        = (sel_q == WR_WE) && (x_q == xmax_q) && (y_q == ymax_q);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      sel_q   <= WR_COLOR;
    end else begin
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
      sel_q   <= sel_d;
    end
  end

  // Raster walk; row/column ends use equality so the top coordinate never wraps.
  always_comb begin
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
    sel_d   = sel_q;
    if (accept) begin
      xmin_d  = (cmd_x0_i <= cmd_x1_i) ? cmd_x0_i : cmd_x1_i;
      xmax_d  = (cmd_x0_i <= cmd_x1_i) ? cmd_x1_i : cmd_x0_i;
      ymin_d  = (cmd_y0_i <= cmd_y1_i) ? cmd_y0_i : cmd_y1_i;
      ymax_d  = (cmd_y0_i <= cmd_y1_i) ? cmd_y1_i : cmd_y0_i;
      x_d     = xmin_d;
      y_d     = ymin_d;
      color_d = cmd_color_i;
      sel_d   = WR_COLOR;
    end else if (ack && !last) begin
      case (sel_q)
        WR_COLOR: sel_d = ROW_START;
`ifdef VGA_RECT_ELIDE_EN
        WR_Y:     sel_d = WR_X;
        WR_X:     sel_d = WR_WE;
`else
        WR_X:     sel_d = WR_Y;
        WR_Y:     sel_d = WR_WE;
`endif
        default: begin
          if (x_q == xmax_q) begin
            x_d   = xmin_q;
            y_d   = y_q + 1'b1;
            sel_d = ROW_START;
          end else begin
            x_d   = x_q + 1'b1;
            sel_d = WR_X;
          end
        end
      endcase
    end
  end

  always_comb begin
    wr_addr = BASE_ADDR + APB_ADDR_WIDTH'(reg_offset(sel_q));
    case (sel_q)
      WR_COLOR: wr_data = APB_DATA_WIDTH'(color_q);
      WR_X:     wr_data = APB_DATA_WIDTH'(x_q);
      WR_Y:     wr_data = APB_DATA_WIDTH'(y_q);
      default:  wr_data = APB_DATA_WIDTH'(1);
    endcase
  end

  apb_master_port #(
    .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
    .APB_DATA_WIDTH (APB_DATA_WIDTH)
  ) u_port (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .start_i   (accept),
    .last_i    (last),
    .addr_i    (wr_addr),
    .data_i    (wr_data),
    .pready_i  (apb_pready_i),
    .pslverr_i (apb_pslverr_i),
    .psel_o    (apb_psel_o),
    .penable_o (apb_penable_o),
    .pwrite_o  (apb_pwrite_o),
    .paddr_o   (apb_paddr_o),
    .pwdata_o  (apb_pwdata_o),
    .idle_o    (idle),
    .ack_o     (ack),
    .done_o    (done_o),
    .err_o     (err_o),
    .state_o   (state_dbg)
  );

endmodule

// File: tb/tb_vga_rect_apb_master.sv
// Directed bench for vga_rect_apb_master: expected APB writes and done records
// are queued at issue time and popped by an independent bus monitor.
module tb_vga_rect_apb_master;
  import vga_apb_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int CW = 11;

`ifdef VGA_RECT_ELIDE_EN
  localparam int N_1X1 = 4;
  localparam int N_2X2 = 11;
  localparam int N_3X1 = 8;
  localparam int N_2X1 = 6;
`else
  localparam int N_1X1 = 4;
  localparam int N_2X2 = 13;
  localparam int N_3X1 = 10;
  localparam int N_2X1 = 7;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [1:0]    color = '0;
  logic          busy, done, err;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pwrite, psel, penable;
  logic [DW-1:0] prdata = 32'hDEAD_BEEF;
  logic          pready = 1'b0, pslverr = 1'b0;

  vga_rect_apb_master dut (
    .clk_i         (clk),
    .rstn_i        (rst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_x0_i      (x0),
    .cmd_y0_i      (y0),
    .cmd_x1_i      (x1),
    .cmd_y1_i      (y1),
    .cmd_color_i   (color),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .apb_paddr_o   (paddr),
    .apb_pwdata_o  (pwdata),
    .apb_pwrite_o  (pwrite),
    .apb_psel_o    (psel),
    .apb_penable_o (penable),
    .apb_prdata_i  (prdata),
    .apb_pready_i  (pready),
    .apb_pslverr_i (pslverr)
  );

  // scoreboard state
  logic [AW+DW-1:0] exp_q[$];
  logic [16:0]      exp_done_q[$];
  int n_vec = 0;
  int n_miss = 0;
  int err_at = -1, wait_at = -1, wait_cycles = 0, waited = 0, xfer_num = 0;
  int setup_cnt = 0;
  bit err_pending = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [AW+DW-1:0] mk(input int off, input int data);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = AW'(off);
    d = DW'(data);
    return {a, d};
  endfunction

  function automatic rect_cmd_t mkcmd(input int ax, input int ay, input int bx, input int by, input int c);
    rect_cmd_t r;
    r.x0 = CW'(ax);
    r.y0 = CW'(ay);
    r.x1 = CW'(bx);
    r.y1 = CW'(by);
    r.color = 2'(c);
    return r;
  endfunction

  // APB slave: zero-wait by default, optional wait states and slave error.
  always @(posedge clk) begin
    #1;
    if (pready) xfer_num++;
    if (psel && penable) begin
      if (xfer_num == wait_at && waited < wait_cycles) begin
        pready  = 1'b0;
        pslverr = 1'b0;
        waited++;
      end else begin
        pready  = 1'b1;
        pslverr = (xfer_num == err_at);
      end
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
    end
  end

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      logic [AW+DW-1:0] e;
      logic [16:0]      d;
      if (err_pending) begin
        check("done_after_err", done, 1);
        err_pending = 1'b0;
      end
      if (psel && !penable) setup_cnt++;
      if (psel && penable && pready) begin
        check("pwrite", pwrite, 1);
        if (exp_q.size() == 0) check("unexpected_xfer", {paddr, pwdata}, 0);
        else begin
          e = exp_q.pop_front();
          check("xfer_addr_data", {paddr, pwdata}, e);
        end
        if (pslverr) err_pending = 1'b1;
      end
      if (done) begin
        check("done_psel", psel, 0);
        if (exp_done_q.size() == 0) check("unexpected_done", done, 0);
        else begin
          d = exp_done_q.pop_front();
          check("done_err", err, d[16]);
          check("setup_count", setup_cnt, d[15:0]);
        end
        setup_cnt = 0;
      end
    end
  end

  // driver tasks (entered and left on a negedge)
  task automatic push_rect(input int xa, input int xb, input int ya, input int yb, input int c);
    exp_q.push_back(mk(8, c));
    for (int y = ya; y <= yb; y++) begin
      for (int x = xa; x <= xb; x++) begin
`ifdef VGA_RECT_ELIDE_EN
        if (x == xa) exp_q.push_back(mk(4, y));
        exp_q.push_back(mk(0, x));
`else
        exp_q.push_back(mk(0, x));
        exp_q.push_back(mk(4, y));
`endif
        exp_q.push_back(mk(12, 1));
      end
    end
  endtask

  task automatic send_cmd(input rect_cmd_t c);
    int i = 0;
    while (!cmd_ready && i < 100) begin
      @(negedge clk);
      i++;
    end
    xfer_num  = 0;
    waited    = 0;
    x0        = c.x0;
    y0        = c.y0;
    x1        = c.x1;
    y1        = c.y1;
    color     = c.color;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_accept", {busy, cmd_ready}, 2'b10);
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (!done && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (!done) check("done_timeout", done, 1);
    @(negedge clk);
    check("idle_after_done", {busy, cmd_ready, psel}, 3'b010);
  endtask

  task automatic run_rect(input rect_cmd_t c, input int xa, input int xb, input int ya, input int yb, input int n);
    push_rect(xa, xb, ya, yb, c.color);
    exp_done_q.push_back({1'b0, 16'(n)});
    send_cmd(c);
    wait_done(300);
  endtask

  initial begin
    int i;
    repeat (3) @(negedge clk);
    check("reset_outs", {busy, done, err, psel, penable, pwrite, paddr, pwdata}, 0);
    check("reset_ready", cmd_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // single pixel, swapped corners, 2x2, top-of-range coordinates
    run_rect(mkcmd(5, 7, 5, 7, 2), 5, 5, 7, 7, N_1X1);
    run_rect(mkcmd(0, 0, 1, 1, 1), 0, 1, 0, 1, N_2X2);
    run_rect(mkcmd(3, 4, 1, 4, 3), 1, 3, 4, 4, N_3X1);
    run_rect(mkcmd(2046, 2047, 2047, 2047, 1), 2046, 2047, 2047, 2047, N_2X1);
    run_rect(mkcmd(2047, 2046, 2046, 2047, 0), 2046, 2047, 2046, 2047, N_2X2);

    // slave error on the second transfer aborts the command
    err_at = 1;
    exp_q.push_back(mk(8, 1));
`ifdef VGA_RECT_ELIDE_EN
    exp_q.push_back(mk(4, 0));
`else
    exp_q.push_back(mk(0, 0));
`endif
    exp_done_q.push_back({1'b1, 16'd2});
    send_cmd(mkcmd(0, 0, 1, 1, 1));
    wait_done(100);
    err_at = -1;

    // 3 wait states on the second transfer, with a competing command held valid
    wait_at = 1;
    wait_cycles = 3;
    push_rect(1, 3, 4, 4, 3);
    exp_done_q.push_back({1'b0, 16'(N_3X1)});
    send_cmd(mkcmd(1, 4, 3, 4, 3));
    x0 = 11'd9; y0 = 11'd9; x1 = 11'd9; y1 = 11'd9; color = 2'd0;
    cmd_valid = 1'b1;
    i = 0;
    while (!(psel && penable && xfer_num == 1) && i < 50) begin
      @(negedge clk);
      i++;
    end
    for (int k = 0; k < 3; k++) begin
      check("wait_penable", {psel, penable}, 2'b11);
`ifdef VGA_RECT_ELIDE_EN
      check("wait_addr_data", {paddr, pwdata}, mk(4, 4));
`else
      check("wait_addr_data", {paddr, pwdata}, mk(0, 1));
`endif
      check("wait_not_ready", cmd_ready, 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    wait_done(100);
    wait_at = -1;

    // reset while a transfer is stalled in ACCESS
    wait_at = 0;
    wait_cycles = 50;
    send_cmd(mkcmd(0, 0, 1, 1, 2));
    i = 0;
    while (!(psel && penable) && i < 20) begin
      @(negedge clk);
      i++;
    end
    #2 rst_n = 1'b0;
    #1 check("reset_mid_access", {psel, penable, busy, cmd_ready}, 4'b0001);
    exp_q.delete();
    exp_done_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    setup_cnt = 0;
    wait_at = -1;
    @(negedge clk);
    check("ready_after_reset", {cmd_ready, busy, done}, 3'b100);

    run_rect(mkcmd(5, 7, 5, 7, 2), 5, 5, 7, 7, N_1X1);

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("done_q_drained", exp_done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
